// File: rtl/gshare_bht.sv
// Gshare branch history table: 2^IDX_W saturating counters indexed by PC ^ global history,
// with decoupled lookup/update ports and a post-reset init sweep. Optional BHT_STATS_EN adds counters.
module gshare_bht #(
  parameter int PC_W     = 9,
  parameter int IDX_W    = 5,
  parameter int CTR_W    = 2,
  parameter int HIST_W   = 5,
  parameter int INIT_CTR = (1 << (CTR_W - 1)) - 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  output logic                                  ready,
  input  logic                                  lkp_valid,
  input  logic [PC_W-1:0]                       lkp_pc,
  output logic                                  pred_valid,
  output logic                                  pred_taken,
  output logic [IDX_W-1:0]                      pred_idx,
  input  logic                                  upd_valid,
  input  logic [IDX_W-1:0]                      upd_idx,
  input  logic                                  upd_taken,
  output logic [((HIST_W > 0) ? HIST_W : 1)-1:0] ghr
`ifdef BHT_STATS_EN
  ,
  output logic [31:0]                           stat_total,
  output logic [31:0]                           stat_miss
`endif
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int GHR_W = (HIST_W > 0) ? HIST_W : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [CTR_W-1:0] ctr_tab [DEPTH];

  logic [IDX_W-1:0] ghr_ext, lkp_idx;
  logic [CTR_W-1:0] upd_cur, upd_nxt, lkp_ctr;
  logic             lkp_fire, upd_fire;
  logic             unused_pc;

  assign unused_pc = ^lkp_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) ptr <= ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_INIT && ptr == '1) state_nxt = S_RUN;
  end

  always_comb begin
    ready = (state == S_RUN);
  end

  assign lkp_fire = lkp_valid & ready;
  assign upd_fire = upd_valid & ready;

  always_comb begin
    ghr_ext = '0;
    if (HIST_W > 0) ghr_ext = IDX_W'(ghr);
  end

  assign lkp_idx = lkp_pc[IDX_W-1:0] ^ ghr_ext;

  always_comb begin
    upd_cur = ctr_tab[upd_idx];
    upd_nxt = upd_cur;
    if (upd_taken) begin
      if (upd_cur != '1) upd_nxt = upd_cur + 1'b1;
    end else begin
      if (upd_cur != '0) upd_nxt = upd_cur - 1'b1;
    end
  end

  // Write-first: a same-cycle update to the looked-up entry is visible to the prediction.
  always_comb begin
    lkp_ctr = ctr_tab[lkp_idx];
    if (upd_valid && upd_idx == lkp_idx) lkp_ctr = upd_nxt;
  end

  always_ff @(posedge clk) begin
    if (state == S_INIT)
      ctr_tab[ptr] <= CTR_W'(INIT_CTR);
    else if (upd_fire)
      ctr_tab[upd_idx] <= upd_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else begin
      pred_valid <= lkp_fire;
      if (lkp_fire) begin
        pred_taken <= lkp_ctr[CTR_W-1];
        pred_idx   <= lkp_idx;
      end
    end
  end

  generate
    if (HIST_W == 0) begin : g_no_hist
      assign ghr = '0;
    end else if (HIST_W == 1) begin : g_hist1
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)        ghr <= '0;
        else if (upd_fire) ghr <= upd_taken;
      end
    end else begin : g_histn
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)        ghr <= '0;
        else if (upd_fire) ghr <= {ghr[GHR_W-2:0], upd_taken};
      end
    end
  endgenerate

`ifdef BHT_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_total <= '0;
      stat_miss  <= '0;
    end else if (upd_fire) begin
      if (stat_total != '1) stat_total <= stat_total + 1'b1;
      if (upd_cur[CTR_W-1] != upd_taken && stat_miss != '1) stat_miss <= stat_miss + 1'b1;
    end
  end
`endif

endmodule
